sub_bytes_engine: RTL and testbench

SUB_BYTES_ENGINE -- requirements
Module: sub_bytes_engine

---
 rtl/aes_pkg.sv | 52 +++++
 rtl/sbox_lane.sv | 13 +
 rtl/sub_bytes_engine.sv | 146 ++++++++++++++
 tb/tb_sub_bytes_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FIPS-197 forward/inverse S-box tables, state
// geometry and the engine FSM state type.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sbox_lane.sv
// One combinational byte substitution: forward S-box when i_mode=0,
// inverse S-box when i_mode=1.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  input  logic       i_mode,
  output logic [7:0] o_byte
);

  assign o_byte = i_mode ? INV_SBOX[i_byte] : SBOX[i_byte];

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES (Inv)SubBytes over a 128-bit state, LANES bytes per cycle.
// Defining SUB_BYTES_PIPE_REG_EN registers lookups before write-back (+1 cycle).
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data,
  output logic                   busy
);

  localparam int STEPS = AES_BYTES / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  state_e                     r_state, w_state_next;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_mode;
  logic [AES_BYTES-1:0][7:0]  r_work, r_out, w_work_wb;
  logic [3:0]                 w_base, w_wb_base;
  logic [7:0]                 w_lane_in  [LANES];
  logic [7:0]                 w_lane_out [LANES];
  logic [7:0]                 w_wb_bytes [LANES];
  logic                       w_accept, w_finish, w_wb_en, w_cnt_adv;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_base   = 4'(int'(r_cnt) * LANES);

  // Byte k of the state lives at packed index AES_BYTES-1-k.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lane_in[gi] = r_work[4'(AES_BYTES - 1) - (w_base + 4'(gi))];
    sbox_lane u_lane (
      .i_byte (w_lane_in[gi]),
      .i_mode (r_mode),
      .o_byte (w_lane_out[gi])
    );
  end

`ifdef SUB_BYTES_PIPE_REG_EN
  logic [7:0]       r_pipe [LANES];
  logic [CNT_W-1:0] r_pipe_cnt;
  logic             r_pipe_vld;
  logic             r_issued_all;
  logic             w_issue;

  assign w_issue    = (r_state == BUSY) && !r_issued_all;
  assign w_finish   = (r_state == BUSY) && r_issued_all && r_pipe_vld;
  assign w_wb_en    = (r_state == BUSY) && r_pipe_vld;
  assign w_wb_base  = 4'(int'(r_pipe_cnt) * LANES);
  assign w_wb_bytes = r_pipe;
  assign w_cnt_adv  = w_issue && (r_cnt != CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe       <= '{default: '0};
      r_pipe_cnt   <= '0;
      r_pipe_vld   <= 1'b0;
      r_issued_all <= 1'b0;
    end else if (w_accept) begin
      r_pipe_vld   <= 1'b0;
      r_issued_all <= 1'b0;
    end else if (w_issue) begin
      r_pipe     <= w_lane_out;
      r_pipe_cnt <= r_cnt;
      r_pipe_vld <= 1'b1;
      if (r_cnt == CNT_LAST) begin
        r_issued_all <= 1'b1;
      end
    end
  end
`else
  assign w_finish   = (r_state == BUSY) && (r_cnt == CNT_LAST);
  assign w_wb_en    = (r_state == BUSY);
  assign w_wb_base  = w_base;
  assign w_wb_bytes = w_lane_out;
  assign w_cnt_adv  = (r_state == BUSY) && (r_cnt != CNT_LAST);
`endif

  always_comb begin
    w_work_wb = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_wb[4'(AES_BYTES - 1) - (w_wb_base + 4'(l))] = w_wb_bytes[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = BUSY;
      BUSY:    if (w_finish)  w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // r_out is only loaded on entry to DONE so partial results never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_mode <= 1'b0;
      r_work <= '0;
      r_out  <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_mode <= in_mode;
      r_work <= in_data;
    end else begin
      if (w_cnt_adv) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_wb_en) begin
        r_work <= w_work_wb;
      end
      if (w_finish) begin
        r_out <= w_work_wb;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign out_data  = r_out;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Drives LANES=1, 4 and 16 engines in lockstep and checks them against an
// S-box model derived from GF(2^8) inversion plus the AES affine map.
module tb_sub_bytes_engine;

`ifdef SUB_BYTES_PIPE_REG_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [2:0]   ir, ov, bz;
  logic [127:0] od    [3];
  logic [127:0] prev  [3];
  logic [127:0] res_q [3];
  logic [7:0]   sbox_m [256];
  logic [7:0]   inv_m  [256];
  int           lat_exp [3];
  int           n_checks = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  sub_bytes_engine #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
  sub_bytes_engine #(.LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
  sub_bytes_engine #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .in_mode(in_mode), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_model();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_m[x] = s;
      inv_m[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic m);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = d[127-8*k -: 8];
      r[127-8*k -: 8] = m ? inv_m[b] : sbox_m[b];
    end
    return r;
  endfunction

  // One block through all three engines; hold = extra DONE cycles with out_ready low.
  task automatic run_block(input logic [127:0] d, input logic m, input int hold);
    logic [127:0] exp;
    int  lat [3];
    bit  seen [3];
    int  cyc;
    exp = ref_sub(d, m);
    chk("in_ready_idle", 128'(ir), 128'(3'b111));
    in_data = d; in_mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_mode = ~m;
    out_ready = 1'b1;
    chk("busy_after_accept", 128'({bz, ir}), 128'(6'b111_000));
    for (int i = 0; i < 3; i++) begin seen[i] = 1'b0; lat[i] = -1; end
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2]) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (!seen[i]) begin
          if (ov[i]) begin
            seen[i] = 1'b1;
            lat[i]  = cyc;
          end else begin
            chk($sformatf("out_data_hidden_i%0d", i), od[i], prev[i]);
          end
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("latency_i%0d", i), 128'(lat[i]), 128'(lat_exp[i]));
      chk($sformatf("data_i%0d_mode%0d", i, m), od[i], exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_flags", 128'({ov, ir}), 128'(6'b111_000));
      for (int i = 0; i < 3; i++) chk($sformatf("hold_data_i%0d", i), od[i], exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_to_idle", 128'({ov, ir, bz}), 128'(9'b000_111_000));
    for (int i = 0; i < 3; i++) begin
      res_q[i] = od[i];
      prev[i]  = od[i];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] r, f;
    lat_exp[0] = 16 + PIPE;
    lat_exp[1] = 4 + PIPE;
    lat_exp[2] = 1 + PIPE;
    build_model();
    for (int i = 0; i < 3; i++) prev[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", 128'({ov, bz}), 128'(6'b000_000));
    for (int i = 0; i < 3; i++) chk($sformatf("reset_data_i%0d", i), od[i], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 128'(ir), 128'(3'b111));

    run_block('0, 1'b0, 10);
    chk("zero_fwd_is_63", res_q[0], {16{8'h63}});
    run_block({16{8'h63}}, 1'b1, 2);
    chk("63_inv_is_zero", res_q[1], 128'h0);
    run_block('0, 1'b1, 2);
    chk("zero_inv_is_52", res_q[2], {16{8'h52}});
    run_block({8'h53, 120'h0}, 1'b0, 1);
    chk("fwd_53_is_ed", res_q[0], {8'hed, {15{8'h63}}});
    run_block({16{8'hed}}, 1'b1, 1);
    chk("inv_ed_is_53", res_q[1], {16{8'h53}});

    for (int t = 0; t < 5; t++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      run_block(r, 1'b0, 1);
      f = res_q[0];
      run_block(f, 1'b1, 1);
      for (int i = 0; i < 3; i++) chk($sformatf("round_trip_t%0d_i%0d", t, i), res_q[i], r);
    end

    in_data = {$urandom, $urandom, $urandom, $urandom};
    in_mode = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", 128'({ov, bz, ir}), 128'(9'b000_000_111));
    for (int i = 0; i < 3; i++) chk($sformatf("async_reset_data_i%0d", i), od[i], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("no_output_after_reset", 128'(ov), 128'(3'b000));
    end
    chk("in_ready_after_mid_reset", 128'(ir), 128'(3'b111));
    for (int i = 0; i < 3; i++) prev[i] = '0;

    r = {$urandom, $urandom, $urandom, $urandom};
    run_block(r, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
